// File: rtl/srf_wb_scheduler.sv
// srf_wb_scheduler: pending-write scoreboard, RAW/WAW issue stall and round-robin
// arbitration of the single register-file write port between ALU and load writeback.
module srf_wb_scheduler #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid_i,
    input  logic            issue_wr_i,
    input  logic [AW-1:0]   issue_dst_i,
    input  logic [AW-1:0]   issue_src1_i,
    input  logic [AW-1:0]   issue_src2_i,
    output logic            issue_stall_o,
    input  logic            alu_wb_valid_i,
    input  logic [AW-1:0]   alu_wb_dst_i,
    input  logic [DW-1:0]   alu_wb_data_i,
    output logic            alu_wb_ready_o,
    input  logic            mem_wb_valid_i,
    input  logic [AW-1:0]   mem_wb_dst_i,
    input  logic [DW-1:0]   mem_wb_data_i,
    output logic            mem_wb_ready_o,
    output logic            rf_wr_en_o,
    output logic [AW-1:0]   rf_wr_dst_o,
    output logic [DW-1:0]   rf_wr_data_o,
    output logic [NREG-1:0] busy_mask_o,
    output logic            wb_err_o,
    output logic [15:0]     stall_cnt_o
);
    logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;
    logic            last_mem_q, last_mem_d;
    logic            rf_wr_en_q, rf_wr_en_d;
    logic [AW-1:0]   rf_wr_dst_q, rf_wr_dst_d, wb_dst;
    logic [DW-1:0]   rf_wr_data_q, rf_wr_data_d, wb_data;
    logic            wb_err_q, wb_err_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            alu_gnt, mem_gnt, hs;

    always_comb begin
        issue_stall_o = issue_valid_i & (busy_q[issue_src1_i] | busy_q[issue_src2_i] |
                                         (issue_wr_i & busy_q[issue_dst_i]));
        // Grants are suppressed in reset so a producer never sees a dropped handshake.
        alu_gnt = ~rst & alu_wb_valid_i & (~mem_wb_valid_i | last_mem_q);
        mem_gnt = ~rst & mem_wb_valid_i & ~alu_gnt;
        hs = alu_gnt | mem_gnt;
        wb_dst = alu_gnt ? alu_wb_dst_i : mem_wb_dst_i;
        wb_data = alu_gnt ? alu_wb_data_i : mem_wb_data_i;
        set_vec = (issue_valid_i & ~issue_stall_o & issue_wr_i) ? NREG'(1) << issue_dst_i : '0;
        clr_vec = rf_wr_en_q ? NREG'(1) << rf_wr_dst_q : '0;
        busy_d = (busy_q & ~clr_vec) | set_vec;
        last_mem_d = (alu_wb_valid_i & mem_wb_valid_i) ? mem_gnt : last_mem_q;
        rf_wr_en_d = hs;
        rf_wr_dst_d = hs ? wb_dst : rf_wr_dst_q;
        rf_wr_data_d = hs ? wb_data : rf_wr_data_q;
        wb_err_d = wb_err_q | (hs & ~busy_q[wb_dst]);
        stall_cnt_d = stall_cnt_q + 16'(issue_stall_o & ~&stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_mem_q   <= 1'b1;
            rf_wr_en_q   <= 1'b0;
            rf_wr_dst_q  <= '0;
            rf_wr_data_q <= '0;
            wb_err_q     <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            last_mem_q   <= last_mem_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_dst_q  <= rf_wr_dst_d;
            rf_wr_data_q <= rf_wr_data_d;
            wb_err_q     <= wb_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign alu_wb_ready_o = alu_gnt;
    assign mem_wb_ready_o = mem_gnt;
    assign rf_wr_en_o     = rf_wr_en_q;
    assign rf_wr_dst_o    = rf_wr_dst_q;
    assign rf_wr_data_o   = rf_wr_data_q;
    assign busy_mask_o    = busy_q;
    assign wb_err_o       = wb_err_q;
    assign stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_srf_wb_scheduler.sv
// tb_srf_wb_scheduler: scoreboard-based bench for srf_wb_scheduler.
module tb_srf_wb_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wr;
    logic [3:0]  issue_dst, issue_src1, issue_src2;
    logic        issue_stall;
    logic        alu_v, mem_v, alu_rdy, mem_rdy;
    logic [3:0]  alu_dst, mem_dst;
    logic [15:0] alu_data, mem_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_dst;
    logic [15:0] rf_wr_data;
    logic [15:0] busy_mask;
    logic        wb_err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;
    int exp_sc = 0;
    logic [19:0] sb[$];
    logic        m_last_mem = 1'b1;

    always #5 clk = ~clk;

    srf_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_wr_i(issue_wr), .issue_dst_i(issue_dst),
        .issue_src1_i(issue_src1), .issue_src2_i(issue_src2), .issue_stall_o(issue_stall),
        .alu_wb_valid_i(alu_v), .alu_wb_dst_i(alu_dst), .alu_wb_data_i(alu_data),
        .alu_wb_ready_o(alu_rdy),
        .mem_wb_valid_i(mem_v), .mem_wb_dst_i(mem_dst), .mem_wb_data_i(mem_data),
        .mem_wb_ready_o(mem_rdy),
        .rf_wr_en_o(rf_wr_en), .rf_wr_dst_o(rf_wr_dst), .rf_wr_data_o(rf_wr_data),
        .busy_mask_o(busy_mask), .wb_err_o(wb_err), .stall_cnt_o(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arbiter: predicts grants and pushes expected rf writes in grant order.
    always @(negedge clk) begin
        logic ea, em;
        logic [19:0] e;
        if (rst) begin
            m_last_mem = 1'b1;
            sb.delete();
        end else begin
            if (rf_wr_en) begin
                if (sb.size() == 0) chk("rf_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rf_dst", 32'(rf_wr_dst), 32'(e[19:16]));
                    chk("rf_data", 32'(rf_wr_data), 32'(e[15:0]));
                end
            end
            ea = alu_v & (~mem_v | m_last_mem);
            em = mem_v & ~ea;
            if (alu_v | mem_v) begin
                chk("alu_ready", 32'(alu_rdy), 32'(ea));
                chk("mem_ready", 32'(mem_rdy), 32'(em));
            end
            if (ea) sb.push_back({alu_dst, alu_data});
            if (em) sb.push_back({mem_dst, mem_data});
            if (alu_v & mem_v) m_last_mem = em;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic wr, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
        issue_valid = v;
        issue_wr = wr;
        issue_dst = d;
        issue_src1 = s1;
        issue_src2 = s2;
    endtask

    task automatic stall_is(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, 32'(issue_stall), 32'(exp));
        if (exp) exp_sc++;
        tick();
    endtask

    initial begin
        logic [3:0] ad[4];
        logic [3:0] md[4];
        logic [3:0] seq;
        int ai, mi;
        rst = 1'b1;
        iss(0, 0, 0, 0, 0);
        alu_v = 0; alu_dst = 0; alu_data = 0;
        mem_v = 0; mem_dst = 0; mem_data = 0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_wren", 32'(rf_wr_en), 0);
        chk("rst_err", 32'(wb_err), 0);
        chk("rst_scnt", 32'(stall_cnt), 0);
        tick();

        // RAW on r3
        iss(1, 1, 3, 0, 0);
        stall_is("raw_first", 0);
        iss(1, 0, 0, 3, 0);
        @(negedge clk);
        chk("raw_busy", 32'(busy_mask), 32'h0008);
        chk("raw_b", 32'(issue_stall), 1);
        exp_sc++;
        tick();
        alu_v = 1; alu_dst = 3; alu_data = 16'hA5A5;
        stall_is("raw_c", 1);
        alu_v = 0;
        stall_is("raw_d", 1);
        @(negedge clk);
        chk("raw_release", 32'(issue_stall), 0);
        chk("raw_scnt", 32'(stall_cnt), 32'(exp_sc));
        chk("raw_busy_clr", 32'(busy_mask), 0);
        chk("raw_err", 32'(wb_err), 0);
        tick();

        // WAW on r7
        iss(1, 1, 7, 0, 0);
        stall_is("waw_first", 0);
        iss(1, 1, 7, 0, 0);
        stall_is("waw_a", 1);
        alu_v = 1; alu_dst = 7; alu_data = 16'h0777;
        stall_is("waw_b", 1);
        alu_v = 0;
        stall_is("waw_c", 1);
        stall_is("waw_accept", 0);
        iss(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_busy", 32'(busy_mask), 32'h0080);
        chk("waw_scnt", 32'(stall_cnt), 32'(exp_sc));
        tick();
        alu_v = 1; alu_dst = 7; alu_data = 16'h7070;
        tick();
        alu_v = 0;
        tick();
        @(negedge clk);
        chk("waw_retired", 32'(busy_mask), 0);
        chk("waw_err", 32'(wb_err), 0);
        tick();

        // writeback to a non-pending register
        mem_v = 1; mem_dst = 9; mem_data = 16'h1234;
        tick();
        mem_v = 0;
        @(negedge clk);
        chk("err_set", 32'(wb_err), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 32'(wb_err), 1);
        tick();

        // reset with r4..r7 pending and a handshake in flight
        for (int r = 4; r < 8; r++) begin
            iss(1, 1, 4'(r), 0, 0);
            tick();
        end
        iss(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy_mask), 32'h00F0);
        tick();
        rst = 1; alu_v = 1; alu_dst = 4; alu_data = 16'hDEAD;
        tick();
        rst = 0; alu_v = 0;
        @(negedge clk);
        chk("rst2_busy", 32'(busy_mask), 0);
        chk("rst2_wren", 32'(rf_wr_en), 0);
        chk("rst2_err", 32'(wb_err), 0);
        chk("rst2_scnt", 32'(stall_cnt), 0);
        tick();

        // round-robin under contention
        ad = '{4'd1, 4'd2, 4'd0, 4'd0};
        md = '{4'd5, 4'd6, 4'd0, 4'd0};
        seq = 0; ai = 0; mi = 0;
        for (int c = 0; c < 10 && (ai < 2 || mi < 2); c++) begin
            alu_v = ai < 2; alu_dst = ad[ai]; alu_data = 16'hA000 + 16'(ad[ai]);
            mem_v = mi < 2; mem_dst = md[mi]; mem_data = 16'hB000 + 16'(md[mi]);
            @(negedge clk);
            if (alu_v & alu_rdy) begin ai++; seq = {seq[2:0], 1'b0}; end
            if (mem_v & mem_rdy) begin mi++; seq = {seq[2:0], 1'b1}; end
            tick();
        end
        alu_v = 0; mem_v = 0;
        chk("rr_count", 32'(ai + mi), 4);
        chk("rr_order", 32'(seq), 32'b0101);
        repeat (2) tick();
        @(negedge clk);
        chk("rr_err", 32'(wb_err), 1);
        tick();

        // saturation of stall_cnt
        iss(1, 1, 5, 0, 0);
        tick();
        iss(1, 0, 0, 5, 5);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (4500) @(posedge clk);
        @(negedge clk);
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        chk("sat_stall", 32'(issue_stall), 1);
        tick();
        iss(0, 0, 0, 0, 0);
        alu_v = 1; alu_dst = 5; alu_data = 16'h5555;
        tick();
        alu_v = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        chk("final_busy", 32'(busy_mask), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
